// File: rtl/irq_pkg.sv
// Shared state encoding and constants for the interrupt/exception sequencer.
package irq_pkg;

    typedef enum logic [1:0] {
        USER   = 2'd0,
        WAIT   = 2'd1,
        ENTER  = 2'd2,
        KERNEL = 2'd3
    } irq_state_t;

    // Cause code reported for an undefined-opcode exception.
    localparam logic [2:0] CAUSE_EXC = 3'd7;
    localparam int         N_SRC_MAX = 7;

endpackage

// File: rtl/irq_priority_enc.sv
// Fixed-priority encoder: bit 0 wins; emits a one-hot grant and the winning index.
module irq_priority_enc
#(
    parameter int N_SRC   = 4,
    parameter int CAUSE_W = 3
) (
    input  logic [N_SRC-1:0]   i_req,
    output logic [N_SRC-1:0]   o_grant,
    output logic [CAUSE_W-1:0] o_index
);

    // Scanning from the top down lets the lowest set bit overwrite the rest.
    always_comb begin
        o_grant = '0;
        o_index = '0;
        for (int i = N_SRC - 1; i >= 0; i--) begin
            if (i_req[i]) begin
                o_grant    = '0;
                o_grant[i] = 1'b1;
                o_index    = CAUSE_W'(i);
            end
        end
    end

endmodule

// File: rtl/irq_controller.sv
// Interrupt/exception sequencer for the 5-stage MIPS pipeline; owns the Supervise flag.
// Define IRQ_EDGE_EN for rising-edge request capture (default build is level-sensitive).
module irq_controller
    import irq_pkg::*;
#(
    parameter int N_SRC   = 4,
    parameter int CAUSE_W = 3
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [N_SRC-1:0]   irq_src,
    input  logic               irq_mask_wr,
    input  logic [N_SRC-1:0]   irq_mask_data,
    input  logic               if_stall,
    input  logic               id_branch,
    input  logic               id_eret,
    input  logic               id_undef,
    output logic               IRQ,
    output logic               Supervise,
    output logic [CAUSE_W-1:0] irq_cause,
    output logic [N_SRC-1:0]   irq_ack,
    output logic [N_SRC-1:0]   irq_pending
);

    irq_state_t         r_state;
    irq_state_t         w_stateNext;
    logic [N_SRC-1:0]   r_mask;
    logic [N_SRC-1:0]   r_pending;
    logic [N_SRC-1:0]   w_req;
    logic [N_SRC-1:0]   w_grant;
    logic [N_SRC-1:0]   w_pendNext;
    logic [CAUSE_W-1:0] w_index;
    logic [CAUSE_W-1:0] r_cause;
    logic               r_irq;
    logic               r_supervise;
    logic               w_safe;
    logic               w_exc;
    logic               w_take;

`ifdef IRQ_EDGE_EN
    logic [N_SRC-1:0]   r_srcPrev;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_srcPrev <= '0;
        end else begin
            r_srcPrev <= irq_src & r_mask;
        end
    end

    assign w_req = irq_src & r_mask & ~r_srcPrev;
`else
    assign w_req = irq_src & r_mask;
`endif

    irq_priority_enc #(
        .N_SRC   (N_SRC),
        .CAUSE_W (CAUSE_W)
    ) u_prio (
        .i_req   (r_pending),
        .o_grant (w_grant),
        .o_index (w_index)
    );

    // An undefined opcode pre-empts an interrupt entry in the same cycle.
    assign w_safe     = !if_stall && !id_branch;
    assign w_exc      = id_undef && !if_stall && (r_state == USER || r_state == WAIT);
    assign w_take     = (r_state == WAIT) && w_safe && !w_exc;
    assign irq_ack    = w_take ? w_grant : '0;
    assign w_pendNext = (r_pending | w_req) & ~irq_ack;

    always_comb begin
        w_stateNext = r_state;
        case (r_state)
            USER: begin
                if (w_exc) begin
                    w_stateNext = KERNEL;
                end else if (|w_pendNext) begin
                    w_stateNext = WAIT;
                end
            end
            WAIT: begin
                if (w_exc) begin
                    w_stateNext = KERNEL;
                end else if (w_safe) begin
                    w_stateNext = ENTER;
                end
            end
            ENTER: begin
                w_stateNext = KERNEL;
            end
            KERNEL: begin
                if (id_eret && !if_stall) begin
                    w_stateNext = USER;
                end
            end
            default: begin
                w_stateNext = USER;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state     <= USER;
            r_mask      <= '0;
            r_pending   <= '0;
            r_cause     <= '0;
            r_irq       <= 1'b0;
            r_supervise <= 1'b0;
        end else begin
            r_state     <= w_stateNext;
            r_pending   <= w_pendNext;
            r_irq       <= w_take;
            r_supervise <= (w_stateNext == KERNEL);
            if (irq_mask_wr) begin
                r_mask <= irq_mask_data;
            end
            if (w_take) begin
                r_cause <= w_index;
            end else if (w_exc) begin
                r_cause <= CAUSE_W'(CAUSE_EXC);
            end
        end
    end

    assign IRQ         = r_irq;
    assign Supervise   = r_supervise;
    assign irq_cause   = r_cause;
    assign irq_pending = r_pending;

endmodule

// File: tb/tb_irq_controller.sv
// Self-checking bench for irq_controller: directed scenarios plus randomized traffic
// compared every cycle against a behavioural model of the sequencing rules.
module tb_irq_controller;

    localparam int N = 4;
    localparam logic [3:0] C_NONE  = 4'b0000;
    localparam logic [3:0] C_STALL = 4'b1000;
    localparam logic [3:0] C_BR    = 4'b0100;
    localparam logic [3:0] C_UNDEF = 4'b0010;
    localparam logic [3:0] C_ERET  = 4'b0001;
`ifdef IRQ_EDGE_EN
    localparam bit EDGE = 1'b1;
`else
    localparam bit EDGE = 1'b0;
`endif

    logic         clk = 1'b0;
    logic         reset;
    logic [N-1:0] irq_src;
    logic         irq_mask_wr;
    logic [N-1:0] irq_mask_data;
    logic         if_stall;
    logic         id_branch;
    logic         id_eret;
    logic         id_undef;
    logic         IRQ;
    logic         Supervise;
    logic [2:0]   irq_cause;
    logic [N-1:0] irq_ack;
    logic [N-1:0] irq_pending;

    int nChecks = 0;
    int nPass   = 0;

    irq_controller #(
        .N_SRC   (N),
        .CAUSE_W (3)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .irq_src       (irq_src),
        .irq_mask_wr   (irq_mask_wr),
        .irq_mask_data (irq_mask_data),
        .if_stall      (if_stall),
        .id_branch     (id_branch),
        .id_eret       (id_eret),
        .id_undef      (id_undef),
        .IRQ           (IRQ),
        .Supervise     (Supervise),
        .irq_cause     (irq_cause),
        .irq_ack       (irq_ack),
        .irq_pending   (irq_pending)
    );

    always #5 clk = ~clk;

    // Model: what the handler lifecycle looks like from the outside.
    logic [N-1:0] mPend, mMask, mPrev;
    logic         mWaiting, mEntering, mKernel;
    logic [2:0]   mCause;

    function automatic int lowestIndex(input logic [N-1:0] v);
        for (int i = 0; i < N; i++) begin
            if (v[i]) return i;
        end
        return 0;
    endfunction

    function automatic logic [N-1:0] modelAck();
        logic [N-1:0] g;
        g = '0;
        if (mWaiting && !if_stall && !id_branch && !id_undef && mPend != '0) begin
            g[lowestIndex(mPend)] = 1'b1;
        end
        return g;
    endfunction

    function automatic logic [N-1:0] modelNewPend();
        logic [N-1:0] req;
        req = irq_src & mMask;
        if (EDGE) req = req & ~mPrev;
        return (mPend | req) & ~modelAck();
    endfunction

    function automatic logic modelExc();
        return id_undef && !if_stall && !mKernel && !mEntering;
    endfunction

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            mPend     <= '0;
            mMask     <= '0;
            mPrev     <= '0;
            mWaiting  <= 1'b0;
            mEntering <= 1'b0;
            mKernel   <= 1'b0;
            mCause    <= 3'd0;
        end else begin
            mPend <= modelNewPend();
            mPrev <= irq_src & mMask;
            if (irq_mask_wr) mMask <= irq_mask_data;
            if (mEntering) begin
                mEntering <= 1'b0;
                mKernel   <= 1'b1;
            end else if (mKernel) begin
                if (id_eret && !if_stall) mKernel <= 1'b0;
            end else if (modelExc()) begin
                mWaiting <= 1'b0;
                mKernel  <= 1'b1;
                mCause   <= 3'd7;
            end else if (modelAck() != '0) begin
                mWaiting  <= 1'b0;
                mEntering <= 1'b1;
                mCause    <= 3'(lowestIndex(mPend));
            end else if (!mWaiting && modelNewPend() != '0) begin
                mWaiting <= 1'b1;
            end
        end
    end

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        nChecks++;
        if (actual === expected) begin
            nPass++;
        end else begin
            $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, actual, expected, $time);
        end
    endtask

    always @(negedge clk) begin
        if (!reset) begin
            checkOutput("m_irq",   32'(IRQ),         32'(mEntering));
            checkOutput("m_sup",   32'(Supervise),   32'(mKernel));
            checkOutput("m_cause", 32'(irq_cause),   32'(mCause));
            checkOutput("m_ack",   32'(irq_ack),     32'(modelAck()));
            checkOutput("m_pend",  32'(irq_pending), 32'(mPend));
        end
    end

    task automatic applyStimulus(input logic [N-1:0] src, input logic [3:0] ctl,
                                 input logic mwr, input logic [N-1:0] mdata);
        @(posedge clk);
        #1;
        irq_src = src;
        {if_stall, id_branch, id_undef, id_eret} = ctl;
        irq_mask_wr   = mwr;
        irq_mask_data = mdata;
        #2;
    endtask

    task automatic step(input logic [N-1:0] src, input logic [3:0] ctl);
        applyStimulus(src, ctl, 1'b0, '0);
    endtask

    initial begin
        reset = 1'b1;
        irq_src = '0;
        irq_mask_wr = 1'b0;
        irq_mask_data = '0;
        {if_stall, id_branch, id_undef, id_eret} = C_NONE;
        repeat (2) @(posedge clk);
        #3;
        checkOutput("rst_irq",   32'(IRQ),         0);
        checkOutput("rst_sup",   32'(Supervise),   0);
        checkOutput("rst_cause", 32'(irq_cause),   0);
        checkOutput("rst_ack",   32'(irq_ack),     0);
        checkOutput("rst_pend",  32'(irq_pending), 0);
        @(posedge clk);
        #1 reset = 1'b0;

        // Single pulse on source 0: ack, IRQ, then kernel mode.
        applyStimulus('0, C_NONE, 1'b1, 4'b0001);
        step('0, C_NONE);
        step('0, C_NONE);
        step(4'b0001, C_NONE);
        checkOutput("t1_ack_user", 32'(irq_ack), 0);
        step('0, C_NONE);
        checkOutput("t1_ack",  32'(irq_ack),     1);
        checkOutput("t1_pend", 32'(irq_pending), 1);
        step('0, C_NONE);
        checkOutput("t1_irq",   32'(IRQ),       1);
        checkOutput("t1_sup0",  32'(Supervise), 0);
        checkOutput("t1_cause", 32'(irq_cause), 0);
        step('0, C_ERET);
        checkOutput("t1_irq_off", 32'(IRQ),       0);
        checkOutput("t1_sup1",    32'(Supervise), 1);
        step('0, C_NONE);
        checkOutput("t1_sup_ret", 32'(Supervise), 0);

        // Sources 1 and 2 together: 1 first, then 2 after a user cycle.
        applyStimulus('0, C_NONE, 1'b1, 4'b1111);
        step(4'b0110, C_NONE);
        step(4'b0110, C_NONE);
        checkOutput("t2_ack1", 32'(irq_ack), 32'h2);
        step(4'b0100, C_NONE);
        checkOutput("t2_cause1", 32'(irq_cause), 1);
        checkOutput("t2_irq1",   32'(IRQ),       1);
        step(4'b0100, C_ERET);
        step(4'b0100, C_NONE);
        checkOutput("t2_user_sup",  32'(Supervise),   0);
        checkOutput("t2_user_ack",  32'(irq_ack),     0);
        checkOutput("t2_user_pend", 32'(irq_pending), 32'h4);
        step(4'b0100, C_NONE);
        checkOutput("t2_ack2", 32'(irq_ack), 32'h4);
        step('0, C_NONE);
        checkOutput("t2_cause2", 32'(irq_cause), 2);
        step('0, C_ERET);
        step('0, C_NONE);

        // Branch then two stall cycles in WAIT delay the pulse by three cycles.
        step(4'b0001, C_NONE);
        step(4'b0001, C_BR);
        checkOutput("t3_ack_br", 32'(irq_ack), 0);
        step(4'b0001, C_STALL);
        checkOutput("t3_irq_a", 32'(IRQ), 0);
        step(4'b0001, C_STALL);
        checkOutput("t3_irq_b", 32'(IRQ), 0);
        step(4'b0001, C_NONE);
        checkOutput("t3_ack", 32'(irq_ack), 1);
        checkOutput("t3_irq_c", 32'(IRQ), 0);
        step('0, C_NONE);
        checkOutput("t3_irq", 32'(IRQ), 1);
        step('0, C_ERET);
        step('0, C_NONE);

        // Undefined opcode at the safe WAIT cycle beats the interrupt.
        step(4'b0001, C_NONE);
        step(4'b0001, C_UNDEF);
        checkOutput("t4_ack_none", 32'(irq_ack), 0);
        step(4'b0001, C_ERET);
        checkOutput("t4_sup",   32'(Supervise),   1);
        checkOutput("t4_irq",   32'(IRQ),         0);
        checkOutput("t4_cause", 32'(irq_cause),   7);
        checkOutput("t4_pend",  32'(irq_pending), 1);
        step(4'b0001, C_NONE);
        step(4'b0001, C_NONE);
        checkOutput("t4_ack_later", 32'(irq_ack), 1);
        step('0, C_NONE);
        checkOutput("t4_cause_irq", 32'(irq_cause), 0);
        step('0, C_ERET);
        step('0, C_NONE);

        // Asynchronous reset while in the handler with source 2 pending.
        step(4'b0001, C_NONE);
        step(4'b0001, C_NONE);
        step(4'b0100, C_NONE);
        step(4'b0100, C_NONE);
        checkOutput("t5_sup_pre",  32'(Supervise),   1);
        checkOutput("t5_pend_pre", 32'(irq_pending), 32'h4);
        #1 reset = 1'b1;
        #1;
        checkOutput("t5_sup_rst",  32'(Supervise),   0);
        checkOutput("t5_irq_rst",  32'(IRQ),         0);
        checkOutput("t5_pend_rst", 32'(irq_pending), 0);
        @(posedge clk);
        #1 reset = 1'b0;
        repeat (8) step(4'b0100, C_NONE);
        checkOutput("t5_masked_pend", 32'(irq_pending), 0);
        checkOutput("t5_masked_sup",  32'(Supervise),   0);

        // Source 0 held across a handler: re-taken only when level-sensitive.
        applyStimulus('0, C_NONE, 1'b1, 4'b0001);
        step(4'b0001, C_NONE);
        step(4'b0001, C_NONE);
        step(4'b0001, C_NONE);
        step(4'b0001, C_NONE);
        step(4'b0001, C_NONE);
        step(4'b0001, C_ERET);
        step(4'b0001, C_NONE);
        checkOutput("t6_pend", 32'(irq_pending), EDGE ? 0 : 1);
        step(4'b0001, C_NONE);
        step('0, C_NONE);
        checkOutput("t6_irq2", 32'(IRQ), EDGE ? 0 : 1);
        step('0, C_NONE);
        step('0, C_ERET);
        step('0, C_NONE);

        for (int i = 0; i < 3000; i++) begin
            logic [N-1:0] rSrc;
            logic [3:0]   rCtl;
            rSrc = ($urandom_range(0, 2) == 0) ? N'($urandom_range(0, 15)) : '0;
            rCtl = {($urandom_range(0, 3) == 0), ($urandom_range(0, 3) == 0),
                    ($urandom_range(0, 15) == 0), ($urandom_range(0, 2) == 0)};
            applyStimulus(rSrc, rCtl, ($urandom_range(0, 15) == 0), N'($urandom_range(0, 15)));
            if (i == 1500) begin
                #1 reset = 1'b1;
                #2 reset = 1'b0;
            end
        end

        repeat (2) @(posedge clk);
        $display("%0d/%0d checks passed", nPass, nChecks);
        $finish;
    end

endmodule

// File: doc/irq_controller.md
# irq_controller

Interrupt/exception sequencer for the 5-stage MIPS pipeline. It latches and masks peripheral interrupt requests and picks one by fixed priority. It waits for a safe entry point in the decode stage, then pulses `IRQ` to the instruction decoder for one cycle. It owns the `Supervise` (kernel-mode) flag, which gates `IRQ` in the decoder and blocks re-entry until the handler returns.

## Interface
Parameters:
- `N_SRC`, 4: number of interrupt sources; legal range 1..7.
- `CAUSE_W`, 3: width of the cause code; must hold 0..7.

Ports:
- `clk` in 1: system clock.
- `reset` in 1: asynchronous, active-high reset.
- `irq_src` in N_SRC: peripheral requests, held until acked; bit 0 is highest priority.
- `irq_mask_wr` in 1: write strobe for the mask register.
- `irq_mask_data` in N_SRC: new mask value; 1 = source enabled.
- `if_stall` in 1: pipeline stalled this cycle (load-use hazard).
- `id_branch` in 1: the ID instruction is a branch or jump; its delay slot is not a legal entry point.
- `id_eret` in 1: the ID instruction is the handler return (`jr $26`).
- `id_undef` in 1: the decoder flagged an undefined opcode (exception PCSrc).
- `IRQ` out 1: registered one-cycle pulse to the decoder.
- `Supervise` out 1: kernel-mode flag.
- `irq_cause` out CAUSE_W: source index taken, or 7 for an undefined-opcode exception.
- `irq_ack` out N_SRC: one-hot, one-cycle acknowledge to the serviced peripheral.
- `irq_pending` out N_SRC: current pending register (status).

## Operation
- Pending register: `pending <= (pending | (irq_src & mask)) & ~irq_ack` every cycle. Masked sources never set pending; bits already pending survive a mask clear.
- The mask is written on `irq_mask_wr` and takes effect the following cycle. Writes are legal in any state.
- States are USER, WAIT, ENTER and KERNEL.
- USER: if `|pending`, go to WAIT.
- WAIT: entry is safe when `!if_stall && !id_branch`. When safe, latch `irq_cause` = index of the highest-priority pending bit, assert `irq_ack` for that bit, and go to ENTER.
- ENTER: lasts exactly one cycle with `IRQ`=1 and `Supervise`=0, so the decoder's IRQ path fires. Go to KERNEL.
- KERNEL: `Supervise`=1. New pending bits accumulate but are not taken. On `id_eret && !if_stall`, `Supervise` clears next cycle and the state returns to USER.
- Forward progress: after leaving KERNEL, at least one USER cycle passes before WAIT, so one user instruction retires between handlers.
- Undefined opcode: in USER or WAIT with `id_undef && !if_stall`, go directly to KERNEL with `irq_cause`=7. No `IRQ` pulse and no ack; the decoder redirects the PC itself.
  - The exception beats a simultaneous interrupt entry; the interrupt stays pending.
  - `id_undef` in KERNEL is ignored by this block: no state change, and the cause is unchanged.
- `id_eret` outside KERNEL is ignored.

## Timing
- Reset values: state USER, `pending`=0, `mask`=0 (all disabled), `IRQ`=0, `Supervise`=0, `irq_cause`=0, `irq_ack`=0.
- Reset is asynchronous and clears everything mid-handler, including `Supervise`.
- Interrupt latency, from `irq_src` rising to the `IRQ` pulse with no stalls or branches:
  - Cycle 0: the source is sampled into pending.
  - Cycle 1: WAIT.
  - Cycle 2: ENTER, with `IRQ`=1 registered.
  - Cycle 3: `Supervise`=1.
- `irq_ack` is asserted in the same cycle as the WAIT→ENTER transition.
- `irq_cause` holds its value from the ENTER cycle until the next entry.
- Each cycle of `if_stall` or `id_branch` in WAIT delays entry by one cycle. Priority is re-evaluated at the moment of entry, not when WAIT is entered.

## Configuration
- With `IRQ_EDGE_EN` defined:
  - Pending is set on the rising edge of `irq_src & mask`, detected against a registered previous sample.
  - Latency grows by 0 cycles, because edge detection is combinational against the stored sample.
  - A level held high across a handler does not re-trigger.
- Without it: level-sensitive. A source still high after its ack re-pends the next cycle and is re-taken after the handler returns.

## Structure
- `irq_pkg` holds:
  - The state enum (USER, WAIT, ENTER, KERNEL).
  - `CAUSE_EXC` = 3'd7.
  - `N_SRC_MAX` = 7.
- Sub-module `irq_priority_enc` is a fixed-priority encoder from N_SRC bits to a one-hot grant plus a CAUSE_W index. It is purely combinational and instantiated once.

## Test plan
- Mask=4'b0001; pulse `irq_src`[0] high for 1 cycle at cycle 10 → `irq_ack`=4'b0001 at cycle 11, `IRQ`=1 at cycle 12 only, `Supervise`=1 from cycle 13, `irq_cause`=0.
- Mask=4'b1111; sources 2 and 1 rise together → `irq_cause`=1 with ack 4'b0010. After `id_eret`, one USER cycle, then source 2 is taken with `irq_cause`=2.
- Source 0 pending; `id_branch`=1 for 1 cycle and then `if_stall`=1 for 2 cycles during WAIT → `IRQ` pulse delayed exactly 3 cycles.
- `id_undef`=1 in the same cycle that WAIT becomes safe → `Supervise`=1 next cycle, `irq_cause`=7, no `IRQ` pulse, no ack, pending unchanged.
- Assert `reset` in KERNEL with pending=4'b0100 → `Supervise`, `IRQ`, `pending` and `mask` all 0 immediately; `irq_src` held high with mask 0 produces no entry.
- Hold `irq_src`[0] high across a handler → a second entry after return without `IRQ_EDGE_EN`; no second entry with it.
